// File: rtl/pb_pkg.sv
// -----------------------------------------------------------------------------
// pb_pkg
// Shared sizes and types for the pushbutton conditioning slice.
//   NUM_PB     : number of pushbuttons on the board
//   PB_CODE_W  : width of the encoded button index
//   pb_vec_t   : one bit per pushbutton
//   pb_code_t  : encoded button index
//   pb_cnt_w() : debounce counter width for a given tick count
// -----------------------------------------------------------------------------
package pb_pkg;

   localparam int NUM_PB    = 21;
   localparam int PB_CODE_W = 5;

   typedef logic [NUM_PB-1:0]    pb_vec_t;
   typedef logic [PB_CODE_W-1:0] pb_code_t;

   // A one-tick debounce still needs a 1-bit counter so the datapath exists.
   function automatic int pb_cnt_w(input int ticks);
      return (ticks > 1) ? $clog2(ticks) : 1;
   endfunction

endpackage : pb_pkg

// File: rtl/pb_debounce_bit.sv
// -----------------------------------------------------------------------------
// pb_debounce_bit
// Conditions one raw pushbutton: two-flop synchronizer, debounce counter,
// clean level flop and registered edge pulses.
//
// Optional feature macro: PB_RELEASE_EVT_EN (builds the falling-edge pulse
// flop; otherwise rel_pulse is tied low).
//
// Ports:
//   hz100      in   system clock
//   reset      in   asynchronous active-low reset
//   raw        in   raw, asynchronous button input
//   clean      out  debounced level
//   press      out  one-cycle pulse on the debounced rising edge
//   rel_pulse  out  one-cycle pulse on the debounced falling edge
// -----------------------------------------------------------------------------
module pb_debounce_bit
   import pb_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 2
) (
   input  logic hz100,
   input  logic reset,
   input  logic raw,
   output logic clean,
   output logic press,
   output logic rel_pulse
);

   localparam int                CNT_W   = pb_cnt_w(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;
   logic             qualify;

   // The synchronized level has disagreed with clean for DEBOUNCE_TICKS
   // consecutive edges including this one: clean takes s2 at this edge.
   assign qualify = (s2 != clean) && (cnt == CNT_MAX);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours (s2 <= s1 depends on it).
   always_ff @(posedge hz100 or negedge reset) begin
      if (!reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
         press <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;

         // Any single matching sample restarts qualification.
         if (s2 == clean) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            clean <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // Registered alongside clean so the pulse lines up with the first
         // cycle in which clean reads 1.
         press <= qualify & s2;
      end
   end

`ifdef PB_RELEASE_EVT_EN
   always_ff @(posedge hz100 or negedge reset) begin
      if (!reset) begin
         rel_pulse <= 1'b0;
      end else begin
         rel_pulse <= qualify & ~s2;
      end
   end
`else
   assign rel_pulse = 1'b0;
`endif

endmodule : pb_debounce_bit

// File: rtl/pb_conditioner.sv
// -----------------------------------------------------------------------------
// pb_conditioner
// Conditions the raw pushbutton vector for the bargraph / decode logic:
// per-button synchronize + debounce + edge pulses, then a lowest-index
// priority encoder that registers the most recent press as code/strobe.
//
// Optional feature macro: PB_RELEASE_EVT_EN (drives pb_release with
// debounced falling-edge pulses; otherwise pb_release is constant 0).
//
// Ports:
//   hz100       in   system clock (100 Hz)
//   reset       in   asynchronous active-low reset
//   pb_raw      in   raw, asynchronous button inputs
//   pb_clean    out  debounced button levels
//   pb_press    out  one-cycle pulse per debounced rising edge
//   pb_release  out  one-cycle pulse per debounced falling edge
//   code        out  index of the most recently pressed button
//   strobe      out  one-cycle pulse when code is updated
//   held        out  high while any debounced button is high
// -----------------------------------------------------------------------------
module pb_conditioner #(
   parameter int NUM_PB         = pb_pkg::NUM_PB,
   parameter int DEBOUNCE_TICKS = 2
) (
   input  logic                hz100,
   input  logic                reset,
   input  logic [NUM_PB-1:0]   pb_raw,
   output logic [NUM_PB-1:0]   pb_clean,
   output logic [NUM_PB-1:0]   pb_press,
   output logic [NUM_PB-1:0]   pb_release,
   output pb_pkg::pb_code_t    code,
   output logic                strobe,
   output logic                held
);

   pb_pkg::pb_code_t code_nxt;
   logic             any_press;

   for (genvar i = 0; i < NUM_PB; i++) begin : g_bit
      pb_debounce_bit #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
      ) u_bit (
         .hz100     (hz100),
         .reset     (reset),
         .raw       (pb_raw[i]),
         .clean     (pb_clean[i]),
         .press     (pb_press[i]),
         .rel_pulse (pb_release[i])
      );
   end

   // Lowest index wins: scanning downward lets the last hit be the lowest.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      any_press = |pb_press;
      code_nxt  = '0;
      for (int i = NUM_PB - 1; i >= 0; i--) begin
         if (pb_press[i]) begin
            code_nxt = pb_pkg::pb_code_t'(i);
         end
      end
   end

   // Higher simultaneous presses are dropped: press pulses last one cycle,
   // so there is nothing left to encode on the following edge.
   always_ff @(posedge hz100 or negedge reset) begin
      if (!reset) begin
         code   <= '0;
         strobe <= 1'b0;
      end else begin
         strobe <= any_press;
         if (any_press) begin
            code <= code_nxt;
         end
      end
   end

   assign held = |pb_clean;

endmodule : pb_conditioner
